multi_point_frequency_manager: RTL and testbench
================================================

MULTI_POINT_FREQUENCY_MANAGER -- requirements
Module: multi_point_frequency_manager

Interface
REQ-001 Parameters SHALL be:
- NUM_POINTS, default 3, number of monitored points (1..8).
- DATA_WIDTH, default 8, pixel width.
- INDEX_WIDTH, default 12, pixel index width.
- LINE_PIXELS, default 1040, pixels per line (dark plus colour).
- DEFAULT_THRESHOLD, default 96, light threshold.
- DEFAULT_START, default 18, point 0 window start.
- DEFAULT_SPACING, default 256, start offset between points.
- DEFAULT_WIDTH, default 32, window width.

REQ-002 Ports SHALL be (name  direction  width  meaning):
- s00_axi_aclk  in  1  sole clock.
- s00_axi_aresetn  in  1  asynchronous active-low reset.
- pixel_data  in  DATA_WIDTH  pixel value.
- pixel_valid  in  1  pixel strobe.
- start  in  1  start-measurement pulse.
- stop  in  1  stop-measurement pulse.
- clear  in  1  synchronous abort.
- cfg_we  in  1  configuration write strobe.
- cfg_addr  in  5  configuration register address.
- cfg_wdata  in  32  configuration write data.
- res_valid  out  1  result word valid.
- res_index  out  5  result register number.
- res_data  out  32  result value.
- res_ready  in  1  result word accepted.
- busy  out  1  state is RUN or READOUT.
- irq  out  1  readout complete.

Function
REQ-003 The state machine SHALL have states IDLE, RUN, READOUT and DONE, with these transitions:
- IDLE to RUN on start.
- RUN to READOUT on stop.
- READOUT to DONE when the last result word is accepted.
- DONE to RUN on start.
- Any state to IDLE on clear.
REQ-004 On entry to RUN, the pixel counter, window maxima, sample bits and all result counters SHALL be zeroed.
REQ-005 In RUN, each pixel_valid SHALL increment the pixel counter; at LINE_PIXELS-1 the counter SHALL wrap to 0 and all window maxima SHALL clear.
REQ-006 For point k, while start_k <= counter < stop_k on a valid pixel, max_k SHALL become max(max_k, pixel_data).
REQ-007 When counter == stop_k on a valid pixel, sample_k SHALL load (max_k > threshold), compared unsigned with strict greater-than.
REQ-008 Each sample_k load with value 1 SHALL increment high_count_k.
REQ-009 A 0 to 1 transition of sample_k SHALL increment edge_count_k.
REQ-010 All counters SHALL be 32 bits and SHALL saturate at 0xFFFFFFFF.
REQ-011 A window with stop_k <= start_k, or with stop_k >= LINE_PIXELS, SHALL never load its sample and SHALL leave its counters at 0.
REQ-012 Configuration registers SHALL be mapped as follows: address 0 is the threshold (low DATA_WIDTH bits); address 1+2k is start_k; address 2+2k is stop_k (low INDEX_WIDTH bits).
REQ-013 cfg_we SHALL take effect only in IDLE or DONE; writes in RUN or READOUT, or to an unmapped address, SHALL be ignored.
REQ-014 In READOUT, res_valid SHALL assert the cycle after entry, and words SHALL be emitted in this order: index 1+2k carries high_count_k and index 2+2k carries edge_count_k, for k ascending.
REQ-015 res_index and res_data SHALL hold stable while res_valid=1 and res_ready=0; the next word SHALL present the cycle after acceptance, at 1 word/cycle when res_ready is held high.
REQ-016 irq SHALL be 1 exactly while the state is DONE.
REQ-017 Simultaneous events SHALL resolve as follows:
- start and stop together in IDLE or DONE go to RUN.
- In RUN, start is ignored and stop applies.
- clear overrides all other inputs.
- stop outside RUN is ignored.
REQ-018 clear during READOUT SHALL deassert res_valid on the next cycle with no further words emitted.

Reset
REQ-019 Asserting s00_axi_aresetn low SHALL immediately force the following:
- State is IDLE.
- res_valid=0, res_index=0, res_data=0, busy=0, irq=0.
- All counters, maxima and samples are 0.
- threshold=DEFAULT_THRESHOLD.
- start_k=DEFAULT_START+k*DEFAULT_SPACING and stop_k=start_k+DEFAULT_WIDTH.
REQ-020 Reset mid-READOUT SHALL abort the readout with no pending word completing; reset deassertion SHALL be synchronised internally.

Configuration
REQ-021 Macro MPFM_EDGE_COUNT_EN controls the edge counters:
- Defined: edge counters exist and readout is 2*NUM_POINTS words as in REQ-014.
- Undefined: no edge counters are built; readout is NUM_POINTS words, index 1+k carrying high_count_k; addresses are otherwise unchanged.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- Reset defaults: after reset, read out via start, stop and res_ready=1 gives 6 words of value 0, irq=1, with windows 18-50, 274-306 and 530-562.
- Threshold: threshold=96, point 0 pixels equal to 96 for 3 lines, then 97 for 2 lines, gives high_count_0=2 and edge_count_0=1.
- Toggling: point 1 alternates bright and dark every line for 10 lines, starting bright, gives high_count_1=5 and edge_count_1=5.
- Backpressure: res_ready low for 4 cycles on word 3 keeps res_index=3 and res_data stable; the sequence completes in order 1..6.
- Config lockout: cfg_we to address 0 with value 10 in RUN is ignored (threshold stays 96); the same write in DONE is applied.
- Abort: clear or reset asserted mid-READOUT after word 2 gives res_valid=0 the next cycle, irq=0 and state IDLE.

Source files
------------

// File: rtl/multi_point_frequency_manager.sv
// Multi-point frequency manager: per-line window maxima become light samples that drive
// high/edge counters, read out as a word stream. Define MPFM_EDGE_COUNT_EN to build edge counters.

module mpfm_point #(
  parameter int DATA_WIDTH  = 8,
  parameter int INDEX_WIDTH = 12,
  parameter int LINE_PIXELS = 1040
) (
  input  logic                   gclk,
  input  logic                   grst_n,
  input  logic                   init,
  input  logic                   pix_en,
  input  logic                   wrap,
  input  logic [INDEX_WIDTH-1:0] pix_cnt,
  input  logic [DATA_WIDTH-1:0]  pix_data,
  input  logic [INDEX_WIDTH-1:0] win_start,
  input  logic [INDEX_WIDTH-1:0] win_stop,
  input  logic [DATA_WIDTH-1:0]  threshold,
`ifdef MPFM_EDGE_COUNT_EN
  output logic [31:0]            edge_cnt,
`endif
  output logic [31:0]            high_cnt
);
  logic [DATA_WIDTH-1:0] max_q;
  logic                  sample;
  logic                  win_ok, in_win, hit, bright;

  // A window whose stop is never reached (or precedes its start) never samples.
  assign win_ok = (win_stop > win_start) && (32'(win_stop) < 32'(LINE_PIXELS));
  assign in_win = (pix_cnt >= win_start) && (pix_cnt < win_stop);
  assign hit    = win_ok && (pix_cnt == win_stop);
  assign bright = (max_q > threshold);

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      max_q    <= '0;
      sample   <= 1'b0;
      high_cnt <= '0;
    end else if (init) begin
      max_q    <= '0;
      sample   <= 1'b0;
      high_cnt <= '0;
    end else if (pix_en) begin
      if (wrap)
        max_q <= '0;
      else if (in_win && (pix_data > max_q))
        max_q <= pix_data;
      if (hit) begin
        sample <= bright;
        if (bright && (high_cnt != '1))
          high_cnt <= high_cnt + 32'd1;
      end
    end
  end

`ifdef MPFM_EDGE_COUNT_EN
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)
      edge_cnt <= '0;
    else if (init)
      edge_cnt <= '0;
    else if (pix_en && hit && bright && !sample && (edge_cnt != '1))
      edge_cnt <= edge_cnt + 32'd1;
  end
`endif
endmodule

module multi_point_frequency_manager #(
  parameter int NUM_POINTS        = 3,
  parameter int DATA_WIDTH        = 8,
  parameter int INDEX_WIDTH       = 12,
  parameter int LINE_PIXELS       = 1040,
  parameter int DEFAULT_THRESHOLD = 96,
  parameter int DEFAULT_START     = 18,
  parameter int DEFAULT_SPACING   = 256,
  parameter int DEFAULT_WIDTH     = 32
) (
  input  logic                  s00_axi_aclk,
  input  logic                  s00_axi_aresetn,
  input  logic [DATA_WIDTH-1:0] pixel_data,
  input  logic                  pixel_valid,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  clear,
  input  logic                  cfg_we,
  input  logic [4:0]            cfg_addr,
  input  logic [31:0]           cfg_wdata,
  output logic                  res_valid,
  output logic [4:0]            res_index,
  output logic [31:0]           res_data,
  input  logic                  res_ready,
  output logic                  busy,
  output logic                  irq
);
`ifdef MPFM_EDGE_COUNT_EN
  localparam int NUM_WORDS = 2 * NUM_POINTS;
`else
  localparam int NUM_WORDS = NUM_POINTS;
`endif

  typedef enum logic [1:0] {IDLE, RUN, READOUT, DONE} state_t;
  state_t state, next_state;

  // Assertion is immediate; release is retimed to the clock.
  logic [1:0] rst_sync;
  logic       rst_n;
  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) rst_sync <= 2'b00;
    else                  rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n = rst_sync[1];

  logic                                   run_init, pix_en, wrap, cfg_ok;
  logic                                   accept, last_word;
  logic [INDEX_WIDTH-1:0]                 pix_cnt;
  logic [DATA_WIDTH-1:0]                  threshold;
  logic [NUM_POINTS-1:0][INDEX_WIDTH-1:0] win_start, win_stop;
  logic [NUM_POINTS-1:0][31:0]            high_cnt;
`ifdef MPFM_EDGE_COUNT_EN
  logic [NUM_POINTS-1:0][31:0]            edge_cnt;
`endif
  logic [NUM_WORDS-1:0][31:0]             words;
  logic [4:0]                             word_ptr, next_ptr;
  logic [31:0]                            next_data;
  logic                                   unused_cfg_bits;

  assign unused_cfg_bits = ^cfg_wdata[31:INDEX_WIDTH];

  assign run_init  = ((state == IDLE) || (state == DONE)) && start && !clear;
  assign pix_en    = (state == RUN) && pixel_valid && !clear;
  assign wrap      = (pix_cnt == INDEX_WIDTH'(LINE_PIXELS - 1));
  assign cfg_ok    = cfg_we && ((state == IDLE) || (state == DONE));
  assign accept    = res_valid && res_ready;
  assign last_word = (word_ptr == 5'(NUM_WORDS - 1));
  assign next_ptr  = word_ptr + 5'd1;

  // FSM: state register
  always_ff @(posedge s00_axi_aclk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // FSM: next state
  always_comb begin
    next_state = state;
    if (clear)
      next_state = IDLE;
    else begin
      case (state)
        IDLE:    if (start) next_state = RUN;
        RUN:     if (stop) next_state = READOUT;
        READOUT: if (accept && last_word) next_state = DONE;
        DONE:    if (start) next_state = RUN;
        default: next_state = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    busy = (state == RUN) || (state == READOUT);
    irq  = (state == DONE);
  end

  always_ff @(posedge s00_axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      threshold <= DATA_WIDTH'(DEFAULT_THRESHOLD);
      for (int k = 0; k < NUM_POINTS; k++) begin
        win_start[k] <= INDEX_WIDTH'(DEFAULT_START + k * DEFAULT_SPACING);
        win_stop[k]  <= INDEX_WIDTH'(DEFAULT_START + k * DEFAULT_SPACING + DEFAULT_WIDTH);
      end
    end else if (cfg_ok) begin
      if (cfg_addr == 5'd0) threshold <= cfg_wdata[DATA_WIDTH-1:0];
      for (int k = 0; k < NUM_POINTS; k++) begin
        if (cfg_addr == 5'(1 + 2 * k)) win_start[k] <= cfg_wdata[INDEX_WIDTH-1:0];
        if (cfg_addr == 5'(2 + 2 * k)) win_stop[k]  <= cfg_wdata[INDEX_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge rst_n) begin
    if (!rst_n)        pix_cnt <= '0;
    else if (run_init) pix_cnt <= '0;
    else if (pix_en)   pix_cnt <= wrap ? '0 : pix_cnt + 1'b1;
  end

  for (genvar k = 0; k < NUM_POINTS; k++) begin : g_point
    mpfm_point #(
      .DATA_WIDTH (DATA_WIDTH),
      .INDEX_WIDTH(INDEX_WIDTH),
      .LINE_PIXELS(LINE_PIXELS)
    ) u_point (
      .gclk     (s00_axi_aclk),
      .grst_n   (rst_n),
      .init     (run_init),
      .pix_en   (pix_en),
      .wrap     (wrap),
      .pix_cnt  (pix_cnt),
      .pix_data (pixel_data),
      .win_start(win_start[k]),
      .win_stop (win_stop[k]),
      .threshold(threshold),
`ifdef MPFM_EDGE_COUNT_EN
      .edge_cnt (edge_cnt[k]),
`endif
      .high_cnt (high_cnt[k])
    );
  end

  always_comb begin
    for (int k = 0; k < NUM_POINTS; k++) begin
`ifdef MPFM_EDGE_COUNT_EN
      words[2*k]   = high_cnt[k];
      words[2*k+1] = edge_cnt[k];
`else
      words[k]     = high_cnt[k];
`endif
    end
  end

  always_comb begin
    next_data = '0;
    for (int w = 0; w < NUM_WORDS; w++)
      if (next_ptr == 5'(w)) next_data = words[w];
  end

  // The first READOUT cycle loads word 0; each acceptance loads the following word.
  always_ff @(posedge s00_axi_aclk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_index <= '0;
      res_data  <= '0;
      word_ptr  <= '0;
    end else if (clear) begin
      res_valid <= 1'b0;
    end else if (state == READOUT) begin
      if (!res_valid) begin
        res_valid <= 1'b1;
        res_index <= 5'd1;
        res_data  <= words[0];
        word_ptr  <= '0;
      end else if (res_ready) begin
        if (last_word) begin
          res_valid <= 1'b0;
        end else begin
          word_ptr  <= next_ptr;
          res_index <= next_ptr + 5'd1;
          res_data  <= next_data;
        end
      end
    end
  end
endmodule

// File: tb/tb_multi_point_frequency_manager.sv
// Randomized and directed bench for multi_point_frequency_manager against a line-level model.
`timescale 1ns/1ps
module tb_multi_point_frequency_manager;
  localparam int NP = 3;
  localparam int LP = 1040;
`ifdef MPFM_EDGE_COUNT_EN
  localparam int NW = 2 * NP;
`else
  localparam int NW = NP;
`endif

  logic        s00_axi_aclk = 1'b0;
  logic        s00_axi_aresetn;
  logic [7:0]  pixel_data;
  logic        pixel_valid, start, stop, clear, cfg_we, res_ready;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_wdata;
  logic        res_valid, busy, irq;
  logic [4:0]  res_index;
  logic [31:0] res_data;

  always #5 s00_axi_aclk = ~s00_axi_aclk;

  multi_point_frequency_manager dut (
    .s00_axi_aclk   (s00_axi_aclk),
    .s00_axi_aresetn(s00_axi_aresetn),
    .pixel_data     (pixel_data),
    .pixel_valid    (pixel_valid),
    .start          (start),
    .stop           (stop),
    .clear          (clear),
    .cfg_we         (cfg_we),
    .cfg_addr       (cfg_addr),
    .cfg_wdata      (cfg_wdata),
    .res_valid      (res_valid),
    .res_index      (res_index),
    .res_data       (res_data),
    .res_ready      (res_ready),
    .busy           (busy),
    .irq            (irq)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Line-level reference model
  int  m_thr;
  int  m_start[NP];
  int  m_stop[NP];
  int  m_high[NP];
  int  m_edge[NP];
  bit  m_samp[NP];
  bit  m_busy;
  int  px[LP];
  logic [31:0] got_w[NW];

  function automatic void model_clear_counts();
    for (int k = 0; k < NP; k++) begin
      m_high[k] = 0; m_edge[k] = 0; m_samp[k] = 0;
    end
  endfunction

  function automatic void model_reset();
    m_thr = 96;
    for (int k = 0; k < NP; k++) begin
      m_start[k] = 18 + 256 * k;
      m_stop[k]  = m_start[k] + 32;
    end
    model_clear_counts();
    m_busy = 0;
  endfunction

  function automatic bit win_valid(int k);
    return (m_stop[k] > m_start[k]) && (m_stop[k] < LP);
  endfunction

  function automatic void model_line();
    for (int k = 0; k < NP; k++) begin
      int mx;
      bit b;
      mx = 0;
      if (win_valid(k)) begin
        for (int i = m_start[k]; i < m_stop[k]; i++) if (px[i] > mx) mx = px[i];
        b = (mx > m_thr);
        if (b) m_high[k]++;
        if (b && !m_samp[k]) m_edge[k]++;
        m_samp[k] = b;
      end
    end
  endfunction

  function automatic logic [31:0] exp_word(int w);
`ifdef MPFM_EDGE_COUNT_EN
    return (w % 2 == 1) ? 32'(m_edge[w/2]) : 32'(m_high[w/2]);
`else
    return 32'(m_high[w]);
`endif
  endfunction

  function automatic void fill_random();
    for (int i = 0; i < LP; i++) px[i] = int'($urandom_range(0, 255));
  endfunction

  function automatic void fill_win(int k, int v);
    if (win_valid(k))
      for (int i = m_start[k]; i < m_stop[k]; i++) px[i] = v;
  endfunction

  task automatic tick();
    @(posedge s00_axi_aclk); #1;
  endtask

  task automatic cfg_write(input int addr, input int data);
    cfg_we = 1'b1; cfg_addr = 5'(addr); cfg_wdata = 32'(data);
    tick();
    cfg_we = 1'b0;
    if (!m_busy) begin
      if (addr == 0) m_thr = data & 255;
      for (int k = 0; k < NP; k++) begin
        if (addr == 1 + 2 * k) m_start[k] = data & 4095;
        if (addr == 2 + 2 * k) m_stop[k]  = data & 4095;
      end
    end
  endtask

  task automatic do_start();
    start = 1'b1; tick(); start = 1'b0;
    model_clear_counts();
    m_busy = 1;
  endtask

  task automatic do_stop();
    stop = 1'b1; tick(); stop = 1'b0;
    chk("entry_valid_low", res_valid, 0);
    chk("busy_readout", busy, 1);
  endtask

  task automatic drive_line(input bit gaps);
    for (int i = 0; i < LP; i++) begin
      pixel_data = 8'(px[i]); pixel_valid = 1'b1;
      tick();
      if (gaps && $urandom_range(0, 7) == 0) begin
        pixel_valid = 1'b0; tick();
      end
    end
    pixel_valid = 1'b0;
    model_line();
  endtask

  // Accept `upto` words; when all are accepted also check the DONE state.
  task automatic collect(input int upto, input int bp_word, input int bp_cycles, input bit rand_bp);
    for (int w = 0; w < upto; w++) begin
      int n;
      int h;
      n = 0;
      while (!res_valid && n < 20) begin tick(); n++; end
      chk("res_valid", res_valid, 1);
      if (w == 0) chk("first_latency", n, 1);
      else        chk("word_rate", n, 0);
      chk("res_index", res_index, w + 1);
      chk("res_data", res_data, exp_word(w));
      got_w[w] = res_data;
      h = (w == bp_word) ? bp_cycles : (rand_bp ? int'($urandom_range(0, 2)) : 0);
      res_ready = 1'b0;
      for (int c = 0; c < h; c++) begin
        tick();
        chk("hold_valid", res_valid, 1);
        chk("hold_index", res_index, w + 1);
        chk("hold_data", res_data, exp_word(w));
      end
      res_ready = 1'b1; tick(); res_ready = 1'b0;
    end
    if (upto == NW) begin
      chk("valid_after_last", res_valid, 0);
      chk("irq_done", irq, 1);
      chk("busy_done", busy, 0);
      m_busy = 0;
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s00_axi_aresetn = 1'b0;
    pixel_data = '0; pixel_valid = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; res_ready = 1'b0;
    repeat (3) tick();
    chk("rst_res_valid", res_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_irq", irq, 0);
    chk("rst_res_index", res_index, 0);
    chk("rst_res_data", res_data, 0);
    s00_axi_aresetn = 1'b1;
    repeat (3) tick();
    model_reset();

    // Reset defaults: empty run reads all zeros
    do_start();
    do_stop();
    collect(NW, -1, 0, 1'b0);
    for (int w = 0; w < NW; w++) chk("default_zero", got_w[w], 0);

    // Threshold: 96 is not bright, 97 is
    do_start();
    for (int l = 0; l < 5; l++) begin
      fill_random(); fill_win(0, (l < 3) ? 96 : 97); drive_line(1'b0);
    end
    do_stop();
    collect(NW, -1, 0, 1'b0);
    chk("thr_high0", got_w[0], 2);
`ifdef MPFM_EDGE_COUNT_EN
    chk("thr_edge0", got_w[1], 1);
`endif

    // Toggling point 1 with backpressure on word 3
    do_start();
    for (int l = 0; l < 10; l++) begin
      fill_random(); fill_win(1, (l % 2 == 0) ? 200 : 20); drive_line(1'b0);
    end
    do_stop();
    collect(NW, 2, 4, 1'b0);
`ifdef MPFM_EDGE_COUNT_EN
    chk("tog_high1", got_w[2], 5);
    chk("tog_edge1", got_w[3], 5);
`else
    chk("tog_high1", got_w[1], 5);
`endif

    // Config lockout: write in RUN ignored, in DONE applied
    do_start();
    cfg_write(0, 10);
    fill_random(); fill_win(0, 50); drive_line(1'b0);
    do_stop();
    collect(NW, -1, 0, 1'b0);
    chk("lock_run_high0", got_w[0], 0);
    cfg_write(0, 10);
    do_start();
    fill_random(); fill_win(0, 50); drive_line(1'b0);
    do_stop();
    collect(NW, -1, 0, 1'b0);
    chk("lock_done_high0", got_w[0], 1);

    // Abort by clear after word 2
    do_start();
    fill_random(); drive_line(1'b0);
    do_stop();
    collect(2, -1, 0, 1'b0);
    chk("pre_clear_valid", res_valid, 1);
    clear = 1'b1; tick(); clear = 1'b0;
    m_busy = 0;
    chk("clear_valid", res_valid, 0);
    chk("clear_irq", irq, 0);
    chk("clear_busy", busy, 0);
    res_ready = 1'b1;
    repeat (3) begin tick(); chk("clear_no_words", res_valid, 0); end
    res_ready = 1'b0;

    // Abort by reset after word 2; thresholds return to defaults
    do_start();
    fill_random(); drive_line(1'b0);
    do_stop();
    collect(2, -1, 0, 1'b0);
    #2 s00_axi_aresetn = 1'b0;
    #1;
    chk("arst_valid", res_valid, 0);
    chk("arst_irq", irq, 0);
    chk("arst_busy", busy, 0);
    chk("arst_index", res_index, 0);
    chk("arst_data", res_data, 0);
    tick();
    s00_axi_aresetn = 1'b1;
    repeat (3) tick();
    model_reset();
    chk("post_rst_valid", res_valid, 0);
    do_start();
    fill_random(); fill_win(0, 50); drive_line(1'b0);
    do_stop();
    collect(NW, -1, 0, 1'b1);
    chk("post_rst_high0", got_w[0], 0);

    // Randomized configurations, including degenerate and edge-of-line windows
    for (int r = 0; r < 3; r++) begin
      cfg_write(0, int'($urandom_range(0, 255)));
      for (int k = 0; k < NP; k++) begin
        int s, e, sel;
        s = int'($urandom_range(0, 1000));
        sel = int'($urandom_range(0, 5));
        case (sel)
          0: e = s;
          1: e = (s > 5) ? s - 5 : s;
          2: e = LP + int'($urandom_range(0, 3000));
          3: e = LP - 1;
          default: e = s + int'($urandom_range(1, 38));
        endcase
        cfg_write(1 + 2 * k, s);
        cfg_write(2 + 2 * k, e);
      end
      cfg_write(2 * NP + 1 + int'($urandom_range(0, 24 - 2 * NP)), int'($urandom));
      do_start();
      for (int l = 0; l < 2; l++) begin
        fill_random();
        for (int k = 0; k < NP; k++) begin
          int lvl;
          lvl = int'($urandom_range(0, 255));
          if (win_valid(k))
            for (int i = m_start[k]; i < m_stop[k]; i++) px[i] = int'($urandom_range(0, lvl));
        end
        drive_line(1'b1);
      end
      do_stop();
      collect(NW, -1, 0, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
